// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO pair.
// Optional macro MULDIV_DIVIDE_EN builds the divider; otherwise divide ops raise invalid_op.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic             o_invalid_op,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [2:0]       o_state_dbg
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PREP = 3'd1, S_ITER = 3'd2, S_FIX = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_a, r_b, r_opnd, r_hi, r_lo;
  logic [1:0]           r_op;
  logic [2*WIDTH-1:0]   r_acc, w_step, w_mul_step, w_fix;
  logic [WIDTH:0]       w_mul_sum;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign_a, r_sign_b;
  logic                 r_busy, r_done, r_dbz, r_inv;
  logic                 w_busy_nxt, w_done_nxt, w_dbz_nxt, w_inv_nxt;
  logic                 w_op_ok, w_op_div, w_div_zero, w_sign_a, w_sign_b;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;

  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v);
    return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign w_op_div = r_op[1];
  assign w_sign_a = ~r_op[0] & r_a[WIDTH-1];
  assign w_sign_b = ~r_op[0] & r_b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? f_neg_w(r_a) : r_a;
  assign w_mag_b  = w_sign_b ? f_neg_w(r_b) : r_b;

  // Upper half accumulates the product while the multiplier shifts out of the lower half.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

`ifdef MULDIV_DIVIDE_EN
  // Divide reuses r_acc as {remainder, quotient/dividend}.
  logic [WIDTH:0]     w_rem_sh, w_rem_diff;
  logic [2*WIDTH-1:0] w_div_step;
  assign w_op_ok    = 1'b1;
  assign w_div_zero = w_op_div & (r_b == {WIDTH{1'b0}});
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_opnd};
  assign w_div_step = w_rem_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                        : {w_rem_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_step     = w_op_div ? w_div_step : w_mul_step;
`else
  assign w_op_ok    = ~i_op[1];
  assign w_div_zero = 1'b0;
  assign w_step     = w_mul_step;
`endif

  // Sign correction of the finished magnitude result.
  always_comb begin
    w_fix = r_acc;
`ifdef MULDIV_DIVIDE_EN
    if (w_op_div) begin
      w_fix[2*WIDTH-1:WIDTH] = r_sign_a ? f_neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
      w_fix[WIDTH-1:0]       = (r_sign_a ^ r_sign_b) ? f_neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    end else begin
      w_fix = (r_sign_a ^ r_sign_b) ? f_neg_2w(r_acc) : r_acc;
    end
`else
    w_fix = (r_sign_a ^ r_sign_b) ? f_neg_2w(r_acc) : r_acc;
`endif
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_dbz_nxt   = 1'b0;
    w_inv_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_op_ok) begin
          w_state_nxt = S_PREP;
        end else if (i_start) begin
          w_inv_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PREP: begin
        if (w_div_zero) begin
          w_state_nxt = S_DONE;
          w_dbz_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_ITER;
        end
      end
      S_ITER: begin
        if (r_cnt == {CW{1'b0}}) w_state_nxt = S_FIX;
        else                     w_state_nxt = S_ITER;
      end
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State register and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_dbz   <= w_dbz_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  // Operand capture, iteration datapath and HI/LO ownership.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
      r_a <= {WIDTH{1'b0}};
      r_b <= {WIDTH{1'b0}};
      r_op <= 2'b00;
      r_opnd <= {WIDTH{1'b0}};
      r_acc <= {(2*WIDTH){1'b0}};
      r_cnt <= {CW{1'b0}};
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_hi_we) r_hi <= i_wdata;
          if (i_lo_we) r_lo <= i_wdata;
          if (w_state_nxt == S_PREP) begin
            r_a  <= i_rs_val;
            r_b  <= i_rt_val;
            r_op <= i_op;
          end
        end
        S_PREP: begin
          r_sign_a <= w_sign_a;
          r_sign_b <= w_sign_b;
          r_cnt    <= CW'(WIDTH - 1);
          if (w_op_div) begin
            r_opnd <= w_mag_b;
            r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
          end else begin
            r_opnd <= w_mag_a;
            r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
          end
          if (w_div_zero) begin
            r_hi <= r_a;
            r_lo <= {WIDTH{1'b1}};
          end
        end
        S_ITER: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end
        S_FIX: begin
          r_hi <= w_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_invalid_op  = r_inv;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_state_dbg   = r_state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus multi-cycle corner sequences.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs, rt, wdata;
  logic        busy, done, dbz, inv;
  logic [31:0] hi, lo;
  logic [2:0]  st;
  int          ntests = 0;
  int          nfail = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op),
    .i_rs_val(rs), .i_rt_val(rt), .i_hi_we(hi_we), .i_lo_we(lo_we), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_div_by_zero(dbz), .o_invalid_op(inv),
    .o_hi(hi), .o_lo(lo), .o_state_dbg(st)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
    int          exp_cyc;
    logic        exp_dbz;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int ec, input logic ed);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.exp_hi = eh; v.exp_lo = el; v.exp_cyc = ec; v.exp_dbz = ed;
    vecs.push_back(v);
  endtask

  // Start one op at edge 0 and observe 60 cycles; records first done cycle, done count and flag.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int dcyc, output int ndone, output logic dflag);
    dcyc = -1; ndone = 0; dflag = 1'b0;
    @(negedge clk); start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        ndone++;
        if (dcyc < 0) begin dcyc = c; dflag = dbz; end
      end
      if (c < 60) @(negedge clk);
    end
  endtask

  task automatic write_reg(input logic is_hi, input logic [31:0] v);
    @(negedge clk); hi_we = is_hi; lo_we = ~is_hi; wdata = v;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcyc, ndone, c;
    logic dflag;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs = 32'd0; rt = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_flags", {62'd0, dbz, inv}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_state", {61'd0, st}, 64'd0);
    reset = 1'b0;

    add_vec("multu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 35, 1'b0);
    add_vec("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 35, 1'b0);
    add_vec("multu_zero", 2'b01, 32'd0, 32'h89ABCDEF, 32'd0, 32'd0, 35, 1'b0);
    add_vec("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 35, 1'b0);
    add_vec("mult_m1m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 35, 1'b0);
    add_vec("multu_shift", 2'b01, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 35, 1'b0);
    add_vec("mult_maxm1", 2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 35, 1'b0);
    add_vec("multu_80x2", 2'b01, 32'h80000000, 32'd2, 32'd1, 32'd0, 35, 1'b0);
`ifdef MULDIV_DIVIDE_EN
    add_vec("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 35, 1'b0);
    add_vec("divu_by0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 2, 1'b1);
    add_vec("div_minm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 35, 1'b0);
    add_vec("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 35, 1'b0);
    add_vec("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 35, 1'b0);
    add_vec("divu_big", 2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 35, 1'b0);
`endif

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, dcyc, ndone, dflag);
      check({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      check({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].exp_lo});
      check({vecs[i].name, "_cyc"}, 64'(dcyc), 64'(vecs[i].exp_cyc));
      check({vecs[i].name, "_ndone"}, 64'(ndone), 64'd1);
      check({vecs[i].name, "_dbz"}, {63'd0, dflag}, {63'd0, vecs[i].exp_dbz});
      check({vecs[i].name, "_idle"}, {63'd0, busy}, 64'd0);
    end

    // Restarts during ITER and DONE are ignored; MTHI while busy is dropped.
    write_reg(1'b1, 32'hAAAA5555);
    write_reg(1'b0, 32'h5555AAAA);
    @(negedge clk); start = 1'b1; op = 2'b01; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF;
    @(negedge clk); start = 1'b0;
    ndone = 0; dcyc = -1;
    for (int k = 1; k <= 45; k++) begin
      if (done) begin ndone++; if (dcyc < 0) dcyc = k; end
      if (k == 1)  begin check("seq_prep_st", {61'd0, st}, 64'd1); check("seq_busy1", {63'd0, busy}, 64'd1); end
      if (k == 2)  check("seq_iter_st", {61'd0, st}, 64'd2);
      if (k == 20) check("seq_no_partial", {hi, lo}, 64'hAAAA5555_5555AAAA);
      if (k == 34) check("seq_fix_st", {61'd0, st}, 64'd3);
      if (k == 35) begin check("seq_done_st", {61'd0, st}, 64'd4); check("seq_busy35", {63'd0, busy}, 64'd1); end
      if (k == 36) check("seq_busy36", {63'd0, busy}, 64'd0);
      start = (k == 10 || k == 35);
      op = 2'b00; rs = 32'd3; rt = 32'd3;
      hi_we = (k == 12); wdata = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
    end
    check("seq_ndone", 64'(ndone), 64'd1);
    check("seq_dcyc", 64'(dcyc), 64'd35);
    check("seq_result", {hi, lo}, 64'hFFFFFFFE_00000001);

    // MTHI in the same cycle as start: visible at once, then overwritten by the product.
    @(negedge clk); start = 1'b1; op = 2'b01; rs = 32'd3; rt = 32'd5; hi_we = 1'b1; wdata = 32'h77;
    @(negedge clk); start = 1'b0; hi_we = 1'b0;
    check("mthi_start_hi", {32'd0, hi}, 64'h77);
    c = 1;
    while (c < 50 && !done) begin @(negedge clk); c++; end
    check("mthi_start_done", {63'd0, done}, 64'd1);
    check("mthi_start_res", {hi, lo}, 64'd15);

    // Reset mid-operation aborts with no done.
    write_reg(1'b1, 32'h11111111);
`ifdef MULDIV_DIVIDE_EN
    @(negedge clk); start = 1'b1; op = 2'b11; rs = 32'd1000; rt = 32'd3;
`else
    @(negedge clk); start = 1'b1; op = 2'b01; rs = 32'd1000; rt = 32'd3;
`endif
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_state", {61'd0, st}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    write_reg(1'b0, 32'h1234);
    check("mtlo", {32'd0, lo}, 64'h1234);

    // Divide opcode: invalid in the multiply-only build.
    write_reg(1'b1, 32'hCAFE0001);
    write_reg(1'b0, 32'hCAFE0002);
    @(negedge clk); start = 1'b1; op = 2'b10; rs = 32'd10; rt = 32'd2;
    @(negedge clk); start = 1'b0;
`ifdef MULDIV_DIVIDE_EN
    check("divop_inv1", {63'd0, inv}, 64'd0);
    check("divop_busy1", {63'd0, busy}, 64'd1);
    c = 1;
    while (c < 50 && !done) begin @(negedge clk); c++; end
    check("divop_res", {hi, lo}, 64'h00000000_00000005);
`else
    check("divop_inv1", {63'd0, inv}, 64'd1);
    check("divop_busy1", {63'd0, busy}, 64'd0);
    check("divop_state1", {61'd0, st}, 64'd0);
    @(negedge clk);
    check("divop_inv2", {63'd0, inv}, 64'd0);
    check("divop_busy2", {63'd0, busy}, 64'd0);
    check("divop_hilo", {hi, lo}, 64'hCAFE0001_CAFE0002);
`endif
    check("divop_dbz", {63'd0, dbz}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
